// File: rtl/lm07_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lm07_pkg
// Brief    : Shared widths, FSM state type and frame decoding for the LM07
//            temperature monitor.
// Revision : 1.0 - initial release
// ============================================================================
package lm07_pkg;

    localparam int TEMP_W  = 13;
    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACC  = 2'd2
    } state_t;

    // The temperature sits in the top TEMP_W bits; the low bits are status/junk.
    function automatic logic [TEMP_W-1:0] frame_to_temp(input logic [FRAME_W-1:0] frame);
        return TEMP_W'(frame >> (FRAME_W - TEMP_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lm07_avg.sv
`default_nettype none
// ============================================================================
// Module   : lm07_avg
// Brief    : Block averager - accumulates 2**AVG_LOG2 signed samples and
//            publishes their floored mean with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module lm07_avg
    import lm07_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_add,
    input  logic              i_clr,
    input  logic [TEMP_W-1:0] i_sample,
    output logic [TEMP_W-1:0] o_avg_temp,
    output logic              o_avg_valid,
    output logic              o_fire,
    output logic [TEMP_W-1:0] o_avg_new
);

    // The accumulator holds at most 2**AVG_LOG2 samples, so these extra bits
    // are exactly enough to never overflow.
    localparam int c_ACC_W = TEMP_W + AVG_LOG2;
    localparam int c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);

    logic signed [c_ACC_W-1:0] r_acc;
    logic        [c_CNT_W-1:0] r_cnt;
    logic signed [c_ACC_W-1:0] w_sample_ext;
    logic signed [c_ACC_W-1:0] w_sum;

    assign w_sample_ext = c_ACC_W'($signed(i_sample));
    assign w_sum        = r_acc + w_sample_ext;
    // Arithmetic shift floors toward -inf, which is the intended rounding.
    assign o_avg_new    = TEMP_W'(w_sum >>> AVG_LOG2);
    // Exposed so the alarm can update on the same edge as the average.
    assign o_fire       = i_add && !i_clr && (r_cnt == c_LAST);

    // Accumulate samples; on the last one publish the mean and restart the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            o_avg_temp  <= '0;
            o_avg_valid <= 1'b0;
        end else begin
            o_avg_valid <= 1'b0;
            if (i_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (i_add) begin
                if (r_cnt == c_LAST) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    o_avg_temp  <= o_avg_new;
                    o_avg_valid <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lm07_temp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lm07_temp_monitor
// Brief    : Periodically requests LM07 reads, captures the temperature,
//            averages it and drives an over-temperature alarm with
//            hysteresis plus a sticky read-timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module lm07_temp_monitor
    import lm07_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 64,
    parameter int AVG_LOG2      = 2,
    parameter int TIMEOUT       = 32
) (
    input  logic               SYSCLK,
    input  logic               RSTN,
    input  logic               en,
    output logic               rd_req,
    input  logic               rd_valid,
    input  logic [FRAME_W-1:0] rd_data,
    input  logic [TEMP_W-1:0]  th_hi,
    input  logic [TEMP_W-1:0]  th_lo,
    input  logic               err_clr,
    output logic [TEMP_W-1:0]  last_temp,
    output logic [TEMP_W-1:0]  avg_temp,
    output logic               avg_valid,
    output logic               alarm,
    output logic               timeout_err
);

    localparam int                 c_PER_W      = $clog2(SAMPLE_PERIOD);
    localparam logic [c_PER_W-1:0] c_PER_RELOAD = c_PER_W'(SAMPLE_PERIOD - 1);
    localparam int                 c_TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0]  c_TO_LOAD    = c_TO_W'(TIMEOUT);
    localparam logic [c_TO_W-1:0]  c_TO_LAST    = c_TO_W'(1);

    logic [c_PER_W-1:0] r_per_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_tick;
    logic               w_issue;
    logic               w_capture;
    logic               w_expire;
    logic               w_add;
    logic               w_clr;
    logic               w_fire;
    logic [TEMP_W-1:0]  w_avg_new;

    assign w_tick = en && (r_per_cnt == '0);
    assign w_add  = en && (r_state == ACC);
    assign w_clr  = !en;

    // Free-running sample period; parked at full count while disabled.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_per_cnt <= c_PER_RELOAD;
        end else if (!en || (r_per_cnt == '0)) begin
            r_per_cnt <= c_PER_RELOAD;
        end else begin
            r_per_cnt <= r_per_cnt - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; disabling abandons any read in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        w_issue     = 1'b1;
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    // A late-but-valid answer beats an expiring counter.
                    if (rd_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ACC;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        w_expire    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                ACC: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Read timeout: loaded on request, the error fires on the edge it hits zero.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_to_cnt <= '0;
        end else if (w_issue) begin
            r_to_cnt <= c_TO_LOAD;
        end else if ((r_state == BUSY) && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    // Request pulse, sample capture, sticky error and hysteretic alarm.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_req      <= 1'b0;
            last_temp   <= '0;
            timeout_err <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            rd_req <= w_issue;
            if (w_capture) begin
                last_temp <= frame_to_temp(rd_data);
            end
            if (w_expire) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            if (w_fire) begin
                if ($signed(w_avg_new) > $signed(th_hi)) begin
                    alarm <= 1'b1;
                end else if ($signed(w_avg_new) < $signed(th_lo)) begin
                    alarm <= 1'b0;
                end
            end
        end
    end

    lm07_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk         (SYSCLK),
        .rst_n       (RSTN),
        .i_add       (w_add),
        .i_clr       (w_clr),
        .i_sample    (last_temp),
        .o_avg_temp  (avg_temp),
        .o_avg_valid (avg_valid),
        .o_fire      (w_fire),
        .o_avg_new   (w_avg_new)
    );

endmodule
`default_nettype wire

// File: tb/tb_lm07_temp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lm07_temp_monitor
// Brief    : Self-checking bench for lm07_temp_monitor: directed vector table,
//            randomized reads against a reference model, timeout / enable /
//            reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lm07_temp_monitor;

    localparam int c_SP = 64;
    localparam int c_L  = 2;
    localparam int c_TO = 32;
    localparam int c_N  = 4;

    logic        SYSCLK   = 1'b0;
    logic        RSTN     = 1'b0;
    logic        en       = 1'b0;
    logic        rd_valid = 1'b0;
    logic        err_clr  = 1'b0;
    logic [15:0] rd_data  = '0;
    logic [12:0] th_hi    = '0;
    logic [12:0] th_lo    = '0;
    logic        rd_req, avg_valid, alarm, timeout_err;
    logic [12:0] last_temp, avg_temp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_req = -1;

    // Reference model state: pending samples of the current block, results.
    int m_q[$];
    int m_avg   = 0;
    int m_alarm = 0;
    int m_last  = 0;

    typedef struct {
        logic [15:0] frame;
        int hi;
        int lo;
        int e_last;
        int e_valid;
        int e_avg;
        int e_alarm;
    } vec_t;
    vec_t tbl[28];

    lm07_temp_monitor #(
        .SAMPLE_PERIOD (c_SP),
        .AVG_LOG2      (c_L),
        .TIMEOUT       (c_TO)
    ) dut (
        .SYSCLK      (SYSCLK),
        .RSTN        (RSTN),
        .en          (en),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .th_hi       (th_hi),
        .th_lo       (th_lo),
        .err_clr     (err_clr),
        .last_temp   (last_temp),
        .avg_temp    (avg_temp),
        .avg_valid   (avg_valid),
        .alarm       (alarm),
        .timeout_err (timeout_err)
    );

    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    function automatic int s13(input logic [12:0] v);
        return int'($signed(v));
    endfunction

    // Mathematical floor division, independent of any shift trick.
    function automatic int fdiv(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] mk_frame(input int t);
        logic [12:0] tt;
        logic [2:0]  junk;
        tt   = 13'(t);
        junk = 3'($urandom_range(0, 7));
        return {tt, junk};
    endfunction

    function automatic vec_t mk(input logic [15:0] f, input int el, input int ev,
                                input int ea, input int eal);
        vec_t v;
        v.frame = f; v.hi = 400; v.lo = 380;
        v.e_last = el; v.e_valid = ev; v.e_avg = ea; v.e_alarm = eal;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    // Bounded wait for the next rd_req; optionally checks spacing from the last one.
    task automatic wait_req(input int max, input bit chk_period);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (rd_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("rd_req seen", int'(seen), 1);
        if (seen) begin
            if (chk_period && (last_req >= 0)) check("rd_req period", cyc - last_req, c_SP);
            last_req = cyc;
        end
    endtask

    // Reader model: answers 5 cycles after rd_req, then samples the results.
    task automatic serve(input logic [15:0] frame, output int o_last, output int o_valid,
                         output int o_avg, output int o_alarm);
        step();
        check("rd_req single cycle", int'(rd_req), 0);
        repeat (3) step();
        rd_valid = 1'b1;
        rd_data  = frame;
        step();
        rd_valid = 1'b0;
        rd_data  = 16'($urandom);
        o_last   = s13(last_temp);
        step();
        o_valid  = int'(avg_valid);
        o_avg    = s13(avg_temp);
        o_alarm  = int'(alarm);
    endtask

    task automatic model_read(input logic [15:0] frame, output int e_valid);
        int s;
        m_last = s13(frame[15:3]);
        m_q.push_back(m_last);
        e_valid = 0;
        if (m_q.size() == c_N) begin
            s = 0;
            foreach (m_q[k]) s += m_q[k];
            m_avg   = fdiv(s, c_N);
            e_valid = 1;
            if (m_avg > s13(th_hi)) m_alarm = 1;
            else if (m_avg < s13(th_lo)) m_alarm = 0;
            m_q.delete();
        end
    endtask

    task automatic read_and_check(input logic [15:0] frame, input string tag);
        int gl, gv, ga, gal, ev;
        serve(frame, gl, gv, ga, gal);
        model_read(frame, ev);
        check({tag, " last_temp"}, gl, m_last);
        check({tag, " avg_valid"}, gv, ev);
        check({tag, " avg_temp"}, ga, m_avg);
        check({tag, " alarm"}, gal, m_alarm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int n, gl, gv, ga, gal, a, b, t, cmark;
        bit nz, sawreq;

        tbl[0]  = mk(16'h0C80, 400, 0, 0, 0);
        tbl[1]  = mk(16'h0C88, 401, 0, 0, 0);
        tbl[2]  = mk(16'h0C90, 402, 0, 0, 0);
        tbl[3]  = mk(16'h0C98, 403, 1, 401, 1);
        tbl[4]  = mk(16'h0C20, 388, 0, 401, 1);
        tbl[5]  = mk(16'h0C40, 392, 0, 401, 1);
        tbl[6]  = mk(16'h0C2F, 389, 0, 401, 1);
        tbl[7]  = mk(16'h0C38, 391, 1, 390, 1);
        tbl[8]  = mk(16'h0BD8, 379, 0, 390, 1);
        tbl[9]  = mk(16'h0BD8, 379, 0, 390, 1);
        tbl[10] = mk(16'h0BE0, 380, 0, 390, 1);
        tbl[11] = mk(16'h0BD0, 378, 1, 379, 0);
        tbl[12] = mk(16'hFFF8, -1, 0, 379, 0);
        tbl[13] = mk(16'hFFF8, -1, 0, 379, 0);
        tbl[14] = mk(16'hFFF8, -1, 0, 379, 0);
        tbl[15] = mk(16'h0000, 0, 1, -1, 0);
        for (int i = 16; i < 19; i++) tbl[i] = mk(16'h0C80, 400, 0, -1, 0);
        tbl[19] = mk(16'h0C80, 400, 1, 400, 0);
        for (int i = 20; i < 23; i++) tbl[i] = mk(16'h0CD0, 410, 0, 400, 0);
        tbl[23] = mk(16'h0CD0, 410, 1, 410, 1);
        for (int i = 24; i < 27; i++) tbl[i] = mk(16'h0BE0, 380, 0, 410, 1);
        tbl[27] = mk(16'h0BE0, 380, 1, 380, 1);

        // Reset state and first request timing.
        repeat (3) step();
        check("reset rd_req", int'(rd_req), 0);
        check("reset last_temp", s13(last_temp), 0);
        check("reset avg_temp", s13(avg_temp), 0);
        check("reset avg_valid", int'(avg_valid), 0);
        check("reset alarm", int'(alarm), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        RSTN = 1'b1;
        en   = 1'b1;
        n = 0; nz = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (rd_req) break;
            nz |= avg_valid | alarm | timeout_err | (last_temp != 0) | (avg_temp != 0);
        end
        check("first rd_req edge", n, c_SP);
        check("outputs quiet before first req", int'(nz), 0);
        last_req = cyc;

        // Directed vector table.
        for (int i = 0; i < 28; i++) begin
            if (i > 0) wait_req(200, 1'b1);
            th_hi = 13'(tbl[i].hi);
            th_lo = 13'(tbl[i].lo);
            serve(tbl[i].frame, gl, gv, ga, gal);
            check($sformatf("vec%0d last_temp", i), gl, tbl[i].e_last);
            check($sformatf("vec%0d avg_valid", i), gv, tbl[i].e_valid);
            check($sformatf("vec%0d avg_temp", i), ga, tbl[i].e_avg);
            check($sformatf("vec%0d alarm", i), gal, tbl[i].e_alarm);
        end
        m_avg   = tbl[27].e_avg;
        m_alarm = tbl[27].e_alarm;
        m_last  = tbl[27].e_last;

        // Randomized reads against the reference model.
        for (int g = 0; g < 3; g++) begin
            a = int'($urandom_range(0, 300)) - 150;
            b = a + int'($urandom_range(0, 60));
            for (int k = 0; k < c_N; k++) begin
                if ($urandom_range(0, 7) == 0)
                    t = ($urandom_range(0, 1) == 1) ? 4095 : -4096;
                else
                    t = int'($urandom_range(0, 400)) - 200;
                wait_req(200, 1'b1);
                th_lo = 13'(a);
                th_hi = 13'(b);
                read_and_check(mk_frame(t), "rnd");
            end
        end

        // Silent reader: timeout latency, period kept, clear, set-beats-clear.
        wait_req(200, 1'b1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (timeout_err) break;
        end
        check("timeout latency", n, c_TO);
        check("timeout keeps last_temp", s13(last_temp), m_last);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr clears", int'(timeout_err), 0);
        wait_req(200, 1'b1);
        err_clr = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (timeout_err) break;
        end
        check("timeout set beats clear", n, c_TO);
        err_clr = 1'b0;
        step();
        check("timeout_err sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr clears again", int'(timeout_err), 0);

        // Enable drop after two samples discards the partial block.
        th_hi = 13'(50);
        th_lo = 13'(0);
        for (int k = 0; k < 2; k++) begin
            wait_req(200, 1'b1);
            read_and_check(mk_frame(100 + k), "partial");
        end
        en = 1'b0;
        m_q.delete();
        sawreq = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) begin rd_valid = 1'b1; rd_data = 16'h0008; end
            if (i == 11) rd_valid = 1'b0;
            step();
            sawreq |= rd_req;
        end
        check("no rd_req while disabled", int'(sawreq), 0);
        check("disabled rd_valid ignored", s13(last_temp), m_last);
        check("disabled avg_temp held", s13(avg_temp), m_avg);
        check("disabled alarm held", int'(alarm), m_alarm);
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (rd_req) break;
        end
        check("rd_req after re-enable", n, c_SP);
        last_req = cyc;

        // Enable blip mid-BUSY abandons the read; late rd_valid is ignored.
        repeat (2) step();
        en = 1'b0;
        step();
        en = 1'b1;
        cmark = cyc;
        step();
        rd_valid = 1'b1;
        rd_data  = 16'h0010;
        step();
        rd_valid = 1'b0;
        check("abandoned read ignored", s13(last_temp), m_last);
        step();
        check("abandoned read no avg", int'(avg_valid), 0);
        wait_req(200, 1'b0);
        check("rd_req after blip", cyc - cmark, c_SP);
        read_and_check(mk_frame(100), "fresh");
        for (int k = 0; k < 3; k++) begin
            wait_req(200, 1'b1);
            read_and_check(mk_frame(100 + 2 * k), "fresh");
        end

        // Asynchronous reset in the middle of a read.
        wait_req(200, 1'b1);
        repeat (2) step();
        #3 RSTN = 1'b0;
        #1;
        check("async rst rd_req", int'(rd_req), 0);
        check("async rst last_temp", s13(last_temp), 0);
        check("async rst avg_temp", s13(avg_temp), 0);
        check("async rst avg_valid", int'(avg_valid), 0);
        check("async rst alarm", int'(alarm), 0);
        check("async rst timeout_err", int'(timeout_err), 0);
        step();
        RSTN = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (rd_req) break;
        end
        check("rd_req after reset", n, c_SP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
